// File: rtl/control_fsm_mips_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its data tract.
// The FSM side uses the master modport; the data tract uses slave.
interface control_fsm_mips_if #(
    parameter int unsigned COUNT_W = 32
);
    logic [31:0]        i_instruction;
    logic               i_run;
    logic               o_r_1_en;
    logic               o_r_2_en;
    logic               o_w_en;
    logic               o_reg_dst;
    logic               o_is_branch;
    logic               o_is_jump;
    logic [1:0]         o_alu_op_type_1;
    logic [1:0]         o_alu_op_type_2;
    logic               o_alu_op_type_3;
    logic               o_alu_is_signed;
    logic               o_alu_src;
    logic               o_mem_write;
    logic               o_mem_to_reg;
    logic               o_pc_en;
    logic               o_illegal;
    logic               o_halted;
    logic [COUNT_W-1:0] o_instr_count;

    modport master (
        input  i_instruction, i_run,
        output o_r_1_en, o_r_2_en, o_w_en, o_reg_dst, o_is_branch, o_is_jump,
               o_alu_op_type_1, o_alu_op_type_2, o_alu_op_type_3, o_alu_is_signed,
               o_alu_src, o_mem_write, o_mem_to_reg, o_pc_en, o_illegal, o_halted,
               o_instr_count
    );

    modport slave (
        output i_instruction, i_run,
        input  o_r_1_en, o_r_2_en, o_w_en, o_reg_dst, o_is_branch, o_is_jump,
               o_alu_op_type_1, o_alu_op_type_2, o_alu_op_type_3, o_alu_is_signed,
               o_alu_src, o_mem_write, o_mem_to_reg, o_pc_en, o_illegal, o_halted,
               o_instr_count
    );
endinterface

// File: rtl/control_fsm_mips.sv
// Multi-cycle MIPS control unit: FETCH -> DECODE -> EXEC -> MEM -> WB with registered
// control outputs, a one-pulse PC enable per instruction and a retired-instruction counter.
module control_fsm_mips #(
    parameter int unsigned COUNT_W          = 32,
    parameter bit          STALL_ON_ILLEGAL = 1'b0
) (
    input logic                 i_clk,
    input logic                 i_reset,
    control_fsm_mips_if.master  ctrl_io
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;
    typedef enum logic [2:0] {
        KindIllegal, KindR, KindImm, KindLw, KindSw, KindBeq, KindJ
    } kind_e;

    typedef struct packed {
        logic       r_1_en;
        logic       r_2_en;
        logic       w_en;
        logic       reg_dst;
        logic       is_branch;
        logic       is_jump;
        logic [1:0] op_1;
        logic [1:0] op_2;
        logic       is_signed;
        logic       alu_src;
        logic       mem_write;
        logic       mem_to_reg;
        logic       pc_en;
        logic       illegal;
        logic       halted;
    } ctrl_t;

    // IR keeps only {opcode, funct}; register fields are consumed by the data tract.
    function automatic kind_e kind_of(input logic [11:0] ir);
        kind_e k;
        k = KindIllegal;
        case (ir[11:6])
            6'h00: if (ir[5:0] inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                       6'h26, 6'h27, 6'h2A, 6'h2B}) k = KindR;
            6'h08, 6'h09: k = KindImm;
            6'h23: k = KindLw;
            6'h2B: k = KindSw;
            6'h04: k = KindBeq;
            6'h02: k = KindJ;
            default: k = KindIllegal;
        endcase
        return k;
    endfunction

    // Returns {op_1, op_2, is_signed}.
    function automatic logic [4:0] alu_of(input logic [11:0] ir);
        logic [4:0] f;
        f = '0;
        if (ir[11:6] == 6'h00) begin
            case (ir[5:0])
                6'h20: f = 5'b00_00_1;
                6'h21: f = 5'b00_00_0;
                6'h22: f = 5'b00_01_1;
                6'h23: f = 5'b00_01_0;
                6'h24: f = 5'b01_00_0;
                6'h25: f = 5'b01_01_0;
                6'h26: f = 5'b01_10_0;
                6'h27: f = 5'b01_11_0;
                6'h2A: f = 5'b10_00_1;
                6'h2B: f = 5'b10_00_0;
                default: f = '0;
            endcase
        end else begin
            case (ir[11:6])
                6'h08, 6'h23, 6'h2B: f = 5'b00_00_1;
                6'h09:               f = 5'b00_00_0;
                6'h04:               f = 5'b00_01_1;
                default:             f = '0;
            endcase
        end
        return f;
    endfunction

    function automatic ctrl_t ctrl_of(input state_e st, input logic [11:0] ir);
        ctrl_t c;
        kind_e k;
        logic  last;
        c    = '0;
        k    = kind_of(ir);
        last = (st == StWb) || (st == StMem && k == KindSw) ||
               (st == StExec && (k == KindBeq || k == KindJ));
        case (st)
            StDecode: begin
                c.r_1_en = 1'b1;
                c.r_2_en = k inside {KindR, KindSw, KindBeq};
                if (k == KindIllegal) begin
                    c.illegal = 1'b1;
                    c.pc_en   = !STALL_ON_ILLEGAL;
                end
            end
            StExec, StMem, StWb: begin
                c.r_1_en                     = 1'b1;
                c.r_2_en                     = k inside {KindR, KindSw, KindBeq};
                c.reg_dst                    = (k == KindR);
                c.alu_src                    = k inside {KindImm, KindLw, KindSw, KindBeq};
                {c.op_1, c.op_2, c.is_signed} = alu_of(ir);
                c.pc_en                      = last;
                c.w_en                       = last && (st == StWb);
                c.mem_write                  = last && (st == StMem);
                c.mem_to_reg                 = (st == StWb) && (k == KindLw);
                c.is_branch                  = (st == StExec) && (k == KindBeq);
                c.is_jump                    = (st == StExec) && (k == KindJ);
            end
            StHalt:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_e             state_q, state_d;
    logic [11:0]        ir_q, ir_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [COUNT_W-1:0] count_q;
    kind_e              kind_q;
    logic               unused_instr;

    assign kind_q       = kind_of(ir_q);
    assign unused_instr = ^ctrl_io.i_instruction[25:6];

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            StFetch: if (ctrl_io.i_run) begin
                ir_d    = {ctrl_io.i_instruction[31:26], ctrl_io.i_instruction[5:0]};
                state_d = StDecode;
            end
            StDecode: begin
                if (kind_q == KindIllegal) state_d = STALL_ON_ILLEGAL ? StHalt : StFetch;
                else                       state_d = StExec;
            end
            StExec: begin
                if (kind_q inside {KindR, KindImm})      state_d = StWb;
                else if (kind_q inside {KindLw, KindSw}) state_d = StMem;
                else                                     state_d = StFetch;
            end
            StMem:   state_d = (kind_q == KindLw) ? StWb : StFetch;
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
        // Outputs are registered: decode what the next cycle's state and IR will be.
        ctrl_d = ctrl_of(state_d, ir_d);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StFetch;
            ir_q    <= '0;
            ctrl_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
            if (ctrl_d.pc_en && !ctrl_d.illegal) count_q <= count_q + COUNT_W'(1);
        end
    end

    assign ctrl_io.o_r_1_en        = ctrl_q.r_1_en;
    assign ctrl_io.o_r_2_en        = ctrl_q.r_2_en;
    assign ctrl_io.o_w_en          = ctrl_q.w_en;
    assign ctrl_io.o_reg_dst       = ctrl_q.reg_dst;
    assign ctrl_io.o_is_branch     = ctrl_q.is_branch;
    assign ctrl_io.o_is_jump       = ctrl_q.is_jump;
    assign ctrl_io.o_alu_op_type_1 = ctrl_q.op_1;
    assign ctrl_io.o_alu_op_type_2 = ctrl_q.op_2;
    assign ctrl_io.o_alu_op_type_3 = 1'b0;
    assign ctrl_io.o_alu_is_signed = ctrl_q.is_signed;
    assign ctrl_io.o_alu_src       = ctrl_q.alu_src;
    assign ctrl_io.o_mem_write     = ctrl_q.mem_write;
    assign ctrl_io.o_mem_to_reg    = ctrl_q.mem_to_reg;
    assign ctrl_io.o_pc_en         = ctrl_q.pc_en;
    assign ctrl_io.o_illegal       = ctrl_q.illegal;
    assign ctrl_io.o_halted        = ctrl_q.halted;
    assign ctrl_io.o_instr_count   = count_q;

endmodule

// File: tb/tb_control_fsm_mips.sv
// Directed bench for control_fsm_mips: per-cycle vector table for every supported and a few
// illegal instructions, plus hand sequences for reset-in-flight, counter wrap and HALT.
module tb_control_fsm_mips;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    control_fsm_mips_if #(.COUNT_W(32)) if0 ();
    control_fsm_mips_if #(.COUNT_W(2))  if1 ();

    control_fsm_mips #(.COUNT_W(32), .STALL_ON_ILLEGAL(1'b0)) u_dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .ctrl_io (if0)
    );

    control_fsm_mips #(.COUNT_W(2), .STALL_ON_ILLEGAL(1'b1)) u_dut_h (
        .i_clk   (clk),
        .i_reset (rst_n),
        .ctrl_io (if1)
    );

    typedef struct packed {
        logic       r1, r2, w, rd, br, jp;
        logic [1:0] op1, op2;
        logic       op3, sg, src, mw, m2r, pc, ill, hlt;
    } out_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        int ncyc, r2, rd, src, sg, op1, op2, w, mw, m2r, br, jp, ill, inc;
    } vec_t;

    out_t        act0, act1;
    logic [31:0] cnt_act0, cnt_act1;
    logic [31:0] cnt0, cnt1;
    int          checks   = 0;
    int          failures = 0;
    vec_t        tbl[18];

    assign act0 = {if0.o_r_1_en, if0.o_r_2_en, if0.o_w_en, if0.o_reg_dst, if0.o_is_branch,
                   if0.o_is_jump, if0.o_alu_op_type_1, if0.o_alu_op_type_2, if0.o_alu_op_type_3,
                   if0.o_alu_is_signed, if0.o_alu_src, if0.o_mem_write, if0.o_mem_to_reg,
                   if0.o_pc_en, if0.o_illegal, if0.o_halted};
    assign act1 = {if1.o_r_1_en, if1.o_r_2_en, if1.o_w_en, if1.o_reg_dst, if1.o_is_branch,
                   if1.o_is_jump, if1.o_alu_op_type_1, if1.o_alu_op_type_2, if1.o_alu_op_type_3,
                   if1.o_alu_is_signed, if1.o_alu_src, if1.o_mem_write, if1.o_mem_to_reg,
                   if1.o_pc_en, if1.o_illegal, if1.o_halted};
    assign cnt_act0 = if0.o_instr_count;
    assign cnt_act1 = {30'b0, if1.o_instr_count};

    task automatic chk_out(input string nm, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s outputs act=%b exp=%b", nm, a, e);
        end
    endtask

    task automatic chk_val(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", nm, a, e);
        end
    endtask

    task automatic drive(input bit sel, input logic run, input logic [31:0] instr);
        if (sel) begin
            if1.i_run = run;  if1.i_instruction = instr;
        end else begin
            if0.i_run = run;  if0.i_instruction = instr;
        end
    endtask

    // Expected outputs in cycle c (1 = FETCH) of a default-config instruction.
    function automatic out_t exp_out(input vec_t v, input int c);
        out_t e;
        e = '0;
        if (c >= 2) e.r1 = 1'b1;
        if (c == 2 && v.ill != 0) begin
            e.ill = 1'b1;
            e.pc  = 1'b1;
        end else if (c >= 2) begin
            e.r2 = v.r2[0];
        end
        if (c >= 3) begin
            e.rd  = v.rd[0];
            e.op1 = v.op1[1:0];
            e.op2 = v.op2[1:0];
            e.sg  = v.sg[0];
            e.src = v.src[0];
        end
        if (c >= 3 && c == v.ncyc) begin
            e.pc  = 1'b1;
            e.w   = v.w[0];
            e.mw  = v.mw[0];
            e.m2r = v.m2r[0];
            e.br  = v.br[0];
            e.jp  = v.jp[0];
        end
        return e;
    endfunction

    task automatic run_vec(input vec_t v, input bit sel);
        logic [31:0] mask;
        mask = sel ? 32'd3 : 32'hFFFF_FFFF;
        @(negedge clk);
        drive(sel, 1'b1, v.instr);
        for (int c = 1; c <= v.ncyc; c++) begin
            if (c > 1) @(negedge clk);
            // Drop run and scramble the bus: the FSM must finish from its latched IR.
            if (c == 2) drive(sel, 1'b0, 32'hFFFF_FFFF);
            if (c == v.ncyc) begin
                if (sel) cnt1 += v.inc[31:0];
                else     cnt0 += v.inc[31:0];
            end
            chk_out($sformatf("%s c%0d", v.name, c), sel ? act1 : act0, exp_out(v, c));
            chk_val($sformatf("%s c%0d count", v.name, c), sel ? cnt_act1 : cnt_act0,
                    (sel ? cnt1 : cnt0) & mask);
        end
    endtask

    initial begin
        out_t e;
        //        name     instr          n r2 rd src sg op1 op2 w mw m2r br jp ill inc
        tbl[0]  = '{"add",   32'h0022_1820, 4, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[1]  = '{"addu",  32'h0022_1821, 4, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[2]  = '{"sub",   32'h0022_1822, 4, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{"subu",  32'h0022_1823, 4, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1};
        tbl[4]  = '{"and",   32'h0022_1824, 4, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[5]  = '{"or",    32'h0022_1825, 4, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1};
        tbl[6]  = '{"xor",   32'h0022_1826, 4, 1, 1, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 1};
        tbl[7]  = '{"nor",   32'h0022_1827, 4, 1, 1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{"slt",   32'h0022_182A, 4, 1, 1, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[9]  = '{"sltu",  32'h0022_182B, 4, 1, 1, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{"addi",  32'h2022_0005, 4, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[11] = '{"addiu", 32'h2422_0005, 4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[12] = '{"lw",    32'h8C22_0004, 5, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1};
        tbl[13] = '{"sw",    32'hAC22_0004, 4, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        tbl[14] = '{"beq",   32'h1022_0003, 3, 1, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1};
        tbl[15] = '{"j",     32'h0800_0010, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
        tbl[16] = '{"op3f",  32'hFC00_0000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[17] = '{"jr",    32'h0020_0008, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

        cnt0 = '0;
        cnt1 = '0;
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("reset outputs", act0, '0);
        chk_val("reset count", cnt_act0, 32'd0);
        chk_out("reset outputs h", act1, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i], 1'b0);

        // Reset while lw sits in EXEC: outputs clear immediately and WB never happens.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h8C22_0004);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk_val("lw exec r1", {31'b0, act0.r1}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_out("lw reset outputs", act0, '0);
        chk_val("lw reset count", cnt_act0, 32'd0);
        cnt0 = '0;
        cnt1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_out($sformatf("lw after reset %0d", i), act0, '0);
        end
        run_vec(tbl[0], 1'b0);

        // Narrow counter: three adds fill it, the fourth wraps it to zero.
        for (int i = 0; i < 4; i++) run_vec(tbl[0], 1'b1);
        chk_val("count wrap", cnt_act1, 32'd0);

        // Stall-on-illegal: pulse in DECODE without pc_en, then HALT ignores run.
        @(negedge clk);
        drive(1'b1, 1'b1, 32'hFC00_0000);
        chk_out("halt ill c1", act1, '0);
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h0022_1820);
        e     = '0;
        e.r1  = 1'b1;
        e.ill = 1'b1;
        chk_out("halt ill c2", act1, e);
        e     = '0;
        e.hlt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_out($sformatf("halted %0d", i), act1, e);
        end
        chk_val("halted count", cnt_act1, 32'd0);
        drive(1'b1, 1'b0, '0);
        rst_n = 1'b0;
        #1;
        chk_out("halt cleared by reset", act1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(tbl[0], 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
